// File: rtl/spike_master_pkg.sv
// Shared types and constants for the spike-event Wishbone master and the neuron core top.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spike_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVT_RD = 2'd1,
    SPK_RD = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int SYNAPSE_ROW_STRIDE = 32;
  localparam int SPIKE_OUT_WORDS    = 8;

  localparam logic [31:0] DEF_SYNAPSE_BASE   = 32'h3000_0000;
  localparam logic [31:0] DEF_SPIKE_OUT_BASE = 32'h3000_8000;

  // Synapse row for an axon: one row per axon, rows packed at a 32-byte stride.
  function automatic logic [31:0] syn_row_addr(input logic [31:0] base, input logic [7:0] axon);
    return base + ({24'd0, axon} * 32'(SYNAPSE_ROW_STRIDE));
  endfunction

  // k-th 32-bit word of the spike-out block.
  function automatic logic [31:0] spk_word_addr(input logic [31:0] base, input logic [2:0] k);
    return base + {27'd0, k, 2'b00};
  endfunction

endpackage

// File: rtl/spike_packet_master_if.sv
// Wishbone classic bus between the spike packet master and the neuron core slave port.
// Latency: n/a (wires only).
// Backpressure: slave stalls the master by withholding wbm_ack.
// Ports (master view): cyc/stb/we/sel/adr/dat_o out; ack/dat_i in.
interface spike_packet_master_if;
  logic        wbm_cyc;
  logic        wbm_stb;
  logic        wbm_we;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_adr;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack;
  logic [31:0] wbm_dat_i;

  modport master (
    output wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbm_adr, wbm_dat_o,
    input  wbm_ack, wbm_dat_i
  );

  modport slave (
    input  wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbm_adr, wbm_dat_o,
    output wbm_ack, wbm_dat_i
  );
endinterface

// File: rtl/wbm_single_xfer.sv
// Single Wishbone classic read: raises cyc/stb on start, ends on ack or after TIMEOUT_CYCLES.
// Latency: cyc registered one edge after i_start; o_done pulses the cycle after the ending edge.
// Backpressure: i_start is ignored while a transfer is in flight; the slave stalls via ack.
// Ports: i_clk, i_rst_n (async active-low), i_start/i_addr request, o_done/o_timeout/o_rdata
//        result (one-cycle valid), wbm master modport.
module wbm_single_xfer
  import spike_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [31:0]            i_addr,
  output logic                   o_done,
  output logic                   o_timeout,
  output logic [31:0]            o_rdata,
  spike_packet_master_if.master  wbm
);

  // Counter value on which the transfer is abandoned; cyc is then high for
  // exactly TIMEOUT_CYCLES cycles.
  localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic        r_cyc;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [15:0] r_cnt;
  logic        r_done;
  logic        r_timeout;
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cyc     <= 1'b0;
      r_sel     <= 4'h0;
      r_adr     <= 32'h0;
      r_cnt     <= 16'h0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_rdata   <= 32'h0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      if (r_cyc) begin
        // Ack wins over a timeout landing on the same edge.
        if (wbm.wbm_ack) begin
          r_cyc   <= 1'b0;
          r_sel   <= 4'h0;
          r_adr   <= 32'h0;
          r_done  <= 1'b1;
          r_rdata <= wbm.wbm_dat_i;
        end else if (r_cnt == LP_TO_LAST) begin
          // Abandoned transfer reads as zero so the caller can store it blindly.
          r_cyc     <= 1'b0;
          r_sel     <= 4'h0;
          r_adr     <= 32'h0;
          r_done    <= 1'b1;
          r_timeout <= 1'b1;
          r_rdata   <= 32'h0;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end else if (i_start) begin
        r_cyc <= 1'b1;
        r_sel <= 4'hF;
        r_adr <= i_addr;
        r_cnt <= 16'h0;
      end
    end
  end

  assign wbm.wbm_cyc   = r_cyc;
  assign wbm.wbm_stb   = r_cyc;
  assign wbm.wbm_we    = 1'b0;
  assign wbm.wbm_sel   = r_sel;
  assign wbm.wbm_adr   = r_adr;
  assign wbm.wbm_dat_o = 32'h0;

  assign o_done    = r_done;
  assign o_timeout = r_timeout;
  assign o_rdata   = r_rdata;

endmodule

// File: rtl/spike_packet_master.sv
// Turns spike events into synapse-row reads and, at image end, reads the 256-bit spike-out vector.
// Latency: cyc rises the edge after accept; min 3 cycles per non-last event; last event adds 8 reads + DONE.
// Backpressure: evt_ready_o is low from the accept edge until the FSM is back in IDLE.
// Ports: wb_clk_i, wb_rst_i (async active-low); evt_valid_i/evt_axon_i/evt_last_i/evt_ready_o
//        event stream; wbm master modport; spike_vec_o/spike_vec_valid_o result; busy_o;
//        timeout_err_o sticky flag cleared by err_clr_i.
module spike_packet_master
  import spike_master_pkg::*;
#(
  parameter logic [31:0] SYNAPSE_BASE   = DEF_SYNAPSE_BASE,
  parameter logic [31:0] SPIKE_OUT_BASE = DEF_SPIKE_OUT_BASE,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   evt_valid_i,
  input  logic [7:0]             evt_axon_i,
  input  logic                   evt_last_i,
  output logic                   evt_ready_o,
  spike_packet_master_if.master  wbm,
  output logic [255:0]           spike_vec_o,
  output logic                   spike_vec_valid_o,
  output logic                   busy_o,
  output logic                   timeout_err_o,
  input  logic                   err_clr_i
);

  localparam logic [2:0] LP_LAST_WORD = 3'(SPIKE_OUT_WORDS - 1);

  state_t       r_state;
  logic         r_last;
  logic [2:0]   r_k;
  logic [255:0] r_shadow;
  logic [255:0] r_spike_vec;
  logic         r_vec_vld;
  logic         r_busy;
  logic         r_evt_rdy;
  logic         r_to_err;

  logic         w_accept;
  logic         w_start;
  logic [31:0]  w_addr;
  logic         w_done;
  logic         w_to;
  logic [31:0]  w_rdata;

  assign w_accept = r_evt_rdy && evt_valid_i;

  // The next transfer is requested on the same edge the previous one reports
  // done, so the sub-module sees start while cyc is already low: this yields
  // exactly one idle bus cycle between consecutive reads.
  always_comb begin
    w_start = 1'b0;
    w_addr  = 32'h0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_start = 1'b1;
          w_addr  = syn_row_addr(SYNAPSE_BASE, evt_axon_i);
        end
      end
      EVT_RD: begin
        if (w_done && r_last) begin
          w_start = 1'b1;
          w_addr  = spk_word_addr(SPIKE_OUT_BASE, 3'd0);
        end
      end
      SPK_RD: begin
        if (w_done && (r_k != LP_LAST_WORD)) begin
          w_start = 1'b1;
          w_addr  = spk_word_addr(SPIKE_OUT_BASE, r_k + 3'd1);
        end
      end
      default: ;
    endcase
  end

  wbm_single_xfer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_xfer (
    .i_clk    (wb_clk_i),
    .i_rst_n  (wb_rst_i),
    .i_start  (w_start),
    .i_addr   (w_addr),
    .o_done   (w_done),
    .o_timeout(w_to),
    .o_rdata  (w_rdata),
    .wbm      (wbm)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state     <= IDLE;
      r_last      <= 1'b0;
      r_k         <= 3'd0;
      r_shadow    <= '0;
      r_spike_vec <= '0;
      r_vec_vld   <= 1'b0;
      r_busy      <= 1'b0;
      r_evt_rdy   <= 1'b1;
    end else begin
      r_vec_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_last    <= evt_last_i;
            r_state   <= EVT_RD;
            r_evt_rdy <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        EVT_RD: begin
          // The synapse-row data is only a side-effect trigger in the core.
          if (w_done) begin
            if (r_last) begin
              r_k     <= 3'd0;
              r_state <= SPK_RD;
            end else begin
              r_state   <= IDLE;
              r_evt_rdy <= 1'b1;
              r_busy    <= 1'b0;
            end
          end
        end
        SPK_RD: begin
          if (w_done) begin
            // A timed-out word arrives as zero from the transfer unit.
            r_shadow[{r_k, 5'd0} +: 32] <= w_rdata;
            if (r_k == LP_LAST_WORD) begin
              r_state <= DONE;
            end else begin
              r_k <= r_k + 3'd1;
            end
          end
        end
        DONE: begin
          r_spike_vec <= r_shadow;
          r_vec_vld   <= 1'b1;
          r_state     <= IDLE;
          r_evt_rdy   <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_evt_rdy <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error: a new timeout beats a simultaneous clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_to_err <= 1'b0;
    end else if (w_done && w_to) begin
      r_to_err <= 1'b1;
    end else if (err_clr_i) begin
      r_to_err <= 1'b0;
    end
  end

  assign evt_ready_o       = r_evt_rdy;
  assign spike_vec_o       = r_spike_vec;
  assign spike_vec_valid_o = r_vec_vld;
  assign busy_o            = r_busy;
  assign timeout_err_o     = r_to_err;

endmodule

// File: tb/tb_spike_packet_master.sv
// Directed bench for spike_packet_master with a behavioural Wishbone slave.
// Latency: n/a.
// Backpressure: slave ack latency and a no-ack address are set per test.
module tb_spike_packet_master;

  logic         clk;
  logic         rst_n;
  logic         evt_valid;
  logic [7:0]   evt_axon;
  logic         evt_last;
  logic         evt_ready;
  logic [255:0] spike_vec;
  logic         spike_vld;
  logic         busy;
  logic         to_err;
  logic         err_clr;

  spike_packet_master_if bus ();

  spike_packet_master #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .wb_clk_i         (clk),
    .wb_rst_i         (rst_n),
    .evt_valid_i      (evt_valid),
    .evt_axon_i       (evt_axon),
    .evt_last_i       (evt_last),
    .evt_ready_o      (evt_ready),
    .wbm              (bus),
    .spike_vec_o      (spike_vec),
    .spike_vec_valid_o(spike_vld),
    .busy_o           (busy),
    .timeout_err_o    (to_err),
    .err_clr_i        (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Slave controls, written only by the main sequence.
  int          lat = 1;
  logic [31:0] noack_adr = 32'h0;
  logic [15:0] seed = 16'hA5A5;
  logic        stray_req = 1'b0;

  // Slave observations, written only by the slave/monitor processes.
  logic [31:0] adr_log[$];
  int          noack_len = 0;
  int          proto_err = 0;
  int          vld_cnt = 0;

  localparam logic [31:0] SPK = 32'h3000_8000;

  initial begin
    logic prev_cyc;
    logic ack_prev;
    int   cnt;
    logic [31:0] off;
    bus.wbm_ack   = 1'b0;
    bus.wbm_dat_i = 32'h0;
    prev_cyc = 1'b0;
    ack_prev = 1'b0;
    cnt      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.wbm_cyc !== bus.wbm_stb) proto_err++;
      if (bus.wbm_cyc && bus.wbm_sel !== 4'hF) proto_err++;
      if (!bus.wbm_cyc && bus.wbm_sel !== 4'h0) proto_err++;
      if (bus.wbm_we !== 1'b0 || bus.wbm_dat_o !== 32'h0) proto_err++;
      if (ack_prev && bus.wbm_cyc) proto_err++;
      if (bus.wbm_cyc && !prev_cyc) begin
        adr_log.push_back(bus.wbm_adr);
        cnt = 0;
      end
      if (bus.wbm_cyc) begin
        cnt++;
        if (bus.wbm_adr == noack_adr) noack_len = cnt;
      end
      ack_prev = bus.wbm_ack && bus.wbm_cyc;
      if (bus.wbm_cyc && cnt >= lat && bus.wbm_adr != noack_adr) begin
        bus.wbm_ack = 1'b1;
        off = bus.wbm_adr - SPK;
        bus.wbm_dat_i = (off < 32'h20) ? ({seed, 16'h0} + (off >> 2)) : 32'hDEAD_0000;
      end else begin
        bus.wbm_ack   = stray_req;
        bus.wbm_dat_i = 32'h0;
      end
      prev_cyc = bus.wbm_cyc;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (spike_vld) vld_cnt++;
    end
  end

  task automatic apply_event(input logic [7:0] axon, input logic last);
    int n;
    @(negedge clk);
    evt_axon  = axon;
    evt_last  = last;
    evt_valid = 1'b1;
    n = 0;
    while (!evt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_wait: got ready=%b want 1", evt_ready);
    end
    @(posedge clk);
    #1;
    evt_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (n < budget && !(!busy && evt_ready && !bus.wbm_cyc)) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_wait: got busy=%b want 0", busy);
    end
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  axon;
    logic        last;
    int          lat;
    logic [15:0] seed;
    logic [31:0] exp_adr;
    int          exp_reads;
    int          exp_vld;
  } vec_t;

  vec_t        tbl[5];
  int          base;
  int          vbase;
  time         t_acc[4];
  logic [255:0] snap;

  initial begin
    tbl[0] = '{8'h05, 1'b0, 2, 16'h0000, 32'h3000_00A0, 1, 0};
    tbl[1] = '{8'hFF, 1'b1, 1, 16'hA5A5, 32'h3000_1FE0, 9, 1};
    tbl[2] = '{8'h00, 1'b0, 1, 16'h0000, 32'h3000_0000, 1, 0};
    tbl[3] = '{8'h80, 1'b1, 3, 16'h5A5A, 32'h3000_1000, 9, 1};
    tbl[4] = '{8'h01, 1'b0, 1, 16'h0000, 32'h3000_0020, 1, 0};

    evt_valid = 1'b0;
    evt_axon  = 8'h0;
    evt_last  = 1'b0;
    err_clr   = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", 32'(bus.wbm_cyc), 0);
    chk("rst_stb", 32'(bus.wbm_stb), 0);
    chk("rst_adr", bus.wbm_adr, 0);
    chk("rst_ready", 32'(evt_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_vec", 32'(spike_vec != 256'h0), 0);
    chk("rst_err", 32'(to_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      lat   = tbl[i].lat;
      seed  = tbl[i].seed;
      base  = adr_log.size();
      vbase = vld_cnt;
      apply_event(tbl[i].axon, tbl[i].last);
      chk($sformatf("v%0d_cyc_t1", i), 32'(bus.wbm_cyc), 1);
      chk($sformatf("v%0d_ready_low", i), 32'(evt_ready), 0);
      wait_idle(200);
      chk($sformatf("v%0d_reads", i), 32'(adr_log.size() - base), 32'(tbl[i].exp_reads));
      chk($sformatf("v%0d_adr", i), adr_log[base], tbl[i].exp_adr);
      chk($sformatf("v%0d_vld", i), 32'(vld_cnt - vbase), 32'(tbl[i].exp_vld));
      chk($sformatf("v%0d_err", i), 32'(to_err), 0);
      if (tbl[i].last) begin
        for (int k = 0; k < 8; k++) begin
          chk($sformatf("v%0d_spk_adr%0d", i, k), adr_log[base + 1 + k], SPK + 32'(k * 4));
          chk($sformatf("v%0d_word%0d", i, k), spike_vec[k*32 +: 32], {tbl[i].seed, 16'h0} + 32'(k));
        end
      end
    end

    // Timeout on spike word 3.
    lat       = 1;
    seed      = 16'hA5A5;
    noack_adr = SPK + 32'hC;
    base      = adr_log.size();
    vbase     = vld_cnt;
    apply_event(8'h10, 1'b1);
    wait_idle(300);
    chk("to_cyc_len", 32'(noack_len), 4);
    chk("to_err_set", 32'(to_err), 1);
    chk("to_reads", 32'(adr_log.size() - base), 9);
    chk("to_word3", spike_vec[127:96], 32'h0);
    chk("to_word2", spike_vec[95:64], 32'hA5A5_0002);
    chk("to_word4", spike_vec[159:128], 32'hA5A5_0004);
    chk("to_vld", 32'(vld_cnt - vbase), 1);
    noack_adr = 32'h0;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("to_err_clr", 32'(to_err), 0);

    // Four queued events, valid held high.
    lat   = 1;
    base  = adr_log.size();
    vbase = vld_cnt;
    for (int i = 0; i < 4; i++) begin
      int n;
      @(negedge clk);
      evt_axon  = 8'h10 + 8'(i);
      evt_last  = 1'b0;
      evt_valid = 1'b1;
      n = 0;
      while (!evt_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      t_acc[i] = $time;
      #1;
    end
    evt_valid = 1'b0;
    wait_idle(200);
    chk("b2b_reads", 32'(adr_log.size() - base), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_adr%0d", i), adr_log[base + i], 32'h3000_0000 + 32'((16 + i) * 32));
      if (i > 0) chk($sformatf("b2b_gap%0d", i), 32'((t_acc[i] - t_acc[i-1]) >= 30), 1);
    end
    chk("b2b_vld", 32'(vld_cnt - vbase), 0);

    // Stray ack while idle.
    snap  = spike_vec;
    base  = adr_log.size();
    vbase = vld_cnt;
    @(negedge clk);
    stray_req = 1'b1;
    @(negedge clk);
    stray_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_busy", 32'(busy), 0);
    chk("stray_ready", 32'(evt_ready), 1);
    chk("stray_cyc", 32'(bus.wbm_cyc), 0);
    chk("stray_reads", 32'(adr_log.size() - base), 0);
    chk("stray_vld", 32'(vld_cnt - vbase), 0);
    chk("stray_vec", 32'(spike_vec != snap), 0);

    // Reset during spike word 5.
    lat  = 2;
    seed = 16'h1234;
    apply_event(8'h20, 1'b1);
    begin
      int n;
      n = 0;
      while (!(bus.wbm_cyc && bus.wbm_adr == SPK + 32'h14) && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("rstmid_reach", 32'(bus.wbm_cyc && bus.wbm_adr == SPK + 32'h14), 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_cyc", 32'(bus.wbm_cyc), 0);
    chk("rstmid_stb", 32'(bus.wbm_stb), 0);
    chk("rstmid_sel", 32'(bus.wbm_sel), 0);
    chk("rstmid_adr", bus.wbm_adr, 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_vec", 32'(spike_vec != 256'h0), 0);
    chk("rstmid_ready", 32'(evt_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rel_ready", 32'(evt_ready), 1);
    chk("rel_vec", 32'(spike_vec != 256'h0), 0);
    chk("rel_busy", 32'(busy), 0);
    chk("rel_cyc", 32'(bus.wbm_cyc), 0);

    chk("protocol", 32'(proto_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spike_packet_master.md
Name: spike_packet_master

Overview:
- Wishbone classic master that drives the 256x256 neuron core from an input spike-event stream.
- For each accepted axon event, issues one Wishbone read to the matching synapse-matrix row; this read triggers row selection and neuron integration in the core.
- On the last event of an image, reads the 256-bit spike-out block as 8 words and presents the vector downstream.
- Sits between the spike-event source (FIFO/LA/CPU bridge) and the core's Wishbone slave port.

Parameters:
- SYNAPSE_BASE, 32'h30000000, base address of the synapse matrix; row stride 32 bytes.
- SPIKE_OUT_BASE, 32'h30008000, base address of the spike-out block; 8 consecutive 32-bit words.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for wbm_ack_i before abandoning a transfer; range 1..65535.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-low
- evt_valid_i  in  1  event present
- evt_axon_i  in  8  axon index of the event
- evt_last_i  in  1  event is the last of the current image
- evt_ready_o  out  1  event accepted when evt_valid_i & evt_ready_o
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  write enable; always 0
- wbm_sel_o  out  4  byte select; 4'hF during a transfer, else 0
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data; always 0
- wbm_ack_i  in  1  slave acknowledge
- wbm_dat_i  in  32  read data
- spike_vec_o  out  256  spike vector of the last completed image
- spike_vec_valid_o  out  1  one-cycle pulse when spike_vec_o updates
- busy_o  out  1  high in any state other than IDLE
- timeout_err_o  out  1  sticky flag: at least one transfer timed out
- err_clr_i  in  1  synchronous clear of timeout_err_o

Behaviour:
- Reset (async assert, sync release): state IDLE. All Wishbone outputs 0, spike_vec_o 0, spike_vec_valid_o 0, busy_o 0, timeout_err_o 0, evt_ready_o 1. Reset asserted mid-transfer drops cyc/stb immediately; the partially read vector is discarded.
- States and transitions:
  - IDLE: evt_ready_o = 1. On accept, latch axon and last flag, go to EVT_RD.
  - EVT_RD: single read at SYNAPSE_BASE + {axon, 5'b0}; data is discarded. On completion: if last = 0, go to IDLE; if last = 1, clear word counter k and go to SPK_RD.
  - SPK_RD: read at SPIKE_OUT_BASE + {k, 2'b00}. Store wbm_dat_i into spike_vec shadow bits [32k+31:32k]. k increments 0..7; after k = 7 completes, go to DONE.
  - DONE: copy shadow to spike_vec_o, pulse spike_vec_valid_o for one cycle, go to IDLE.
- Transfer timing: for an event accepted at edge T, cyc/stb/adr/sel are registered high from T+1. ack sampled high at edge A ends the transfer; cyc/stb are low at A+1. There is at least one idle cycle between transfers, and cyc and stb are always asserted together.
- evt_ready_o is low from the accept edge until the state returns to IDLE. Back-to-back events therefore take a minimum of 3 cycles each.
- Timeout: a per-transfer counter starts at 0 when cyc rises. If it reaches TIMEOUT_CYCLES with no ack, cyc/stb drop, timeout_err_o is set, and the FSM proceeds as if acked; in SPK_RD the word is stored as 32'h0.
- An ack arriving while cyc is low is ignored.
- err_clr_i and a new timeout in the same cycle: set wins.
- Address arithmetic is 32-bit with no wrap. Axon 255 maps to SYNAPSE_BASE + 32'h1FE0.
- An image consisting of a single event with evt_last_i = 1 is legal: 1 event read + 8 spike reads.
- spike_vec_o holds its value until the next DONE.

Decomposition:
- Shared package spike_master_pkg: state enum (IDLE, EVT_RD, SPK_RD, DONE), SYNAPSE_ROW_STRIDE = 32, SPIKE_OUT_WORDS = 8, and the default base-address constants shared with the core top.
- One sub-module, wbm_single_xfer. It owns cyc/stb/adr/sel, the ack wait, and the timeout counter. Interface: start/addr in; done/timeout/rdata out.

Test Plan:
- Reset, then evt_axon_i = 8'h05 with last = 0; slave acks after 2 cycles -> one read at 32'h300000A0, cyc low the cycle after ack, evt_ready_o returns high, no spike_vec_valid_o.
- Event axon 8'hFF with last = 1; spike-out slave returns word k = 32'hA5A50000 + k -> reads at 32'h30001FE0, then 32'h30008000..3000801C; spike_vec_o[63:32] = 32'hA5A50001; exactly one spike_vec_valid_o pulse.
- Slave never acks on SPK_RD k = 3, TIMEOUT_CYCLES = 4 -> cyc drops 4 cycles after rising, timeout_err_o = 1, spike_vec_o[127:96] = 0, remaining words read normally; err_clr_i then clears the flag.
- evt_valid_i held high with 4 queued events, 1-cycle ack -> each accept is spaced at least 3 cycles apart, no event lost or duplicated, addresses in order.
- wb_rst_i asserted low while cyc is high during SPK_RD k = 5 -> all outputs 0 asynchronously; after release, evt_ready_o = 1 and spike_vec_o = 0.
- Stray wbm_ack_i pulse in IDLE -> no state change, no output change.
